// File: rtl/phy_free_list.sv
// Circular free list of physical register tags for rename, with a head-pointer
// checkpoint per branch page so a mispredict restore returns squashed tags.
module phy_free_list #(
    parameter int PHYS_W    = 8,
    parameter int ARCH_REGS = 32,
    parameter int DEPTH     = 128,
    parameter int PAGES     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exception_sig,
    input  logic              mret_sig,
    input  logic              alloc_req,
    input  logic              if_id_flush,
    output logic [PHYS_W-1:0] alloc_phy,
    output logic              alloc_valid,
    input  logic              release_valid,
    input  logic [PHYS_W-1:0] release_phy,
    input  logic              save_state,
    input  logic [4:0]        save_page,
    input  logic              restore_state,
    input  logic [4:0]        restore_page,
    output logic [7:0]        free_count,
    output logic              overflow_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PHYS_W-1:0] mem  [DEPTH];
    logic [PTR_W-1:0]  ckpt [PAGES];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  eh;
    logic [PTR_W-1:0]  count;
    logic              init;
    logic              pop;
    logic              save;
    logic              push;
    logic              full;

    assign init = reset | exception_sig | mret_sig;

    // A restore redirects this cycle's allocation to the checkpointed head.
    assign eh          = restore_state ? ckpt[restore_page] : head;
    assign alloc_phy   = mem[eh[IDX_W-1:0]];
    assign alloc_valid = (tail != eh);

    assign pop  = alloc_req & alloc_valid & (restore_state | ~if_id_flush);
    assign save = save_state & ~restore_state & ~if_id_flush;
    assign push = release_valid & (release_phy != {PHYS_W{1'b1}});

    // Fullness uses the registered pointers; a same-cycle pop does not free a slot.
    assign count      = tail - head;
    assign full       = (count >= PTR_W'(DEPTH));
    assign free_count = 8'(count);

    always_ff @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PHYS_W'(ARCH_REGS + i);
            end
            for (int p = 0; p < PAGES; p++) begin
                ckpt[p] <= '0;
            end
            head         <= '0;
            tail         <= PTR_W'(DEPTH);
            overflow_err <= 1'b0;
        end else begin
            head <= pop ? eh + PTR_W'(1) : eh;
            if (save) begin
                ckpt[save_page] <= head;
            end
            if (push && !full) begin
                mem[tail[IDX_W-1:0]] <= release_phy;
                tail                 <= tail + PTR_W'(1);
            end else if (push) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phy_free_list.sv
// Directed self-checking bench for phy_free_list: allocation, checkpoint
// save/restore, flush, empty/full boundaries, pointer wrap and reinitialisation.
module tb_phy_free_list;

    logic       clk = 1'b0;
    logic       reset, exception_sig, mret_sig;
    logic       alloc_req, if_id_flush;
    logic [7:0] alloc_phy;
    logic       alloc_valid;
    logic       release_valid;
    logic [7:0] release_phy;
    logic       save_state, restore_state;
    logic [4:0] save_page, restore_page;
    logic [7:0] free_count;
    logic       overflow_err;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] q[$];
    logic [7:0] exp_tag;

    always #5 clk = ~clk;

    phy_free_list dut (
        .clk(clk), .reset(reset), .exception_sig(exception_sig), .mret_sig(mret_sig),
        .alloc_req(alloc_req), .if_id_flush(if_id_flush),
        .alloc_phy(alloc_phy), .alloc_valid(alloc_valid),
        .release_valid(release_valid), .release_phy(release_phy),
        .save_state(save_state), .save_page(save_page),
        .restore_state(restore_state), .restore_page(restore_page),
        .free_count(free_count), .overflow_err(overflow_err)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic idle();
        reset = 0; exception_sig = 0; mret_sig = 0;
        alloc_req = 0; if_id_flush = 0;
        release_valid = 0; release_phy = 8'hFF;
        save_state = 0; save_page = 0; restore_state = 0; restore_page = 0;
    endtask

    // Advance one edge and land just after it; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        cyc();
        reset = 0;
        #1;
    endtask

    initial begin
        idle();
        #1;
        do_reset();
        check("rst_alloc_phy", alloc_phy, 32);
        check("rst_alloc_valid", alloc_valid, 1);
        check("rst_free_count", free_count, 128);
        check("rst_overflow", overflow_err, 0);

        // T1: three allocations
        alloc_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t1_alloc_phy", alloc_phy, 32 + i);
            cyc();
        end
        alloc_req = 0; #1;
        check("t1_free_count", free_count, 125);

        // T2: save page 3 with a same-cycle pop, then restore
        save_state = 1; save_page = 3; alloc_req = 1; #1;
        check("t2_save_alloc", alloc_phy, 35);
        cyc();
        save_state = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_alloc_phy", alloc_phy, 36 + i);
            cyc();
        end
        restore_state = 1; restore_page = 3; #1;
        check("t2_restore_phy", alloc_phy, 35);
        cyc();
        restore_state = 0; alloc_req = 0; #1;
        check("t2_post_phy", alloc_phy, 36);
        check("t2_post_count", free_count, 124);

        // T5: flush suppresses pop and save; restore overrides flush
        alloc_req = 1; if_id_flush = 1; save_state = 1; save_page = 9;
        cyc();
        idle(); #1;
        check("t5_flush_phy", alloc_phy, 36);
        check("t5_flush_count", free_count, 124);
        alloc_req = 1; if_id_flush = 1; restore_state = 1; restore_page = 3;
        cyc();
        idle(); #1;
        check("t5_restore_phy", alloc_phy, 36);
        check("t5_restore_count", free_count, 124);
        restore_state = 1; restore_page = 9; #1;
        check("t5_flush_nosave", alloc_phy, 32);
        cyc();
        idle(); #1;
        check("t5_restore_nopop", free_count, 128);

        // T3: drain to empty, pop on empty, then a single release
        do_reset();
        alloc_req = 1;
        for (int i = 0; i < 128; i++) cyc();
        #1;
        check("t3_empty_valid", alloc_valid, 0);
        check("t3_empty_count", free_count, 0);
        cyc();
        alloc_req = 0; #1;
        check("t3_empty_pop", free_count, 0);
        release_valid = 1; release_phy = 8'd5;
        cyc();
        idle(); #1;
        check("t3_rel_valid", alloc_valid, 1);
        check("t3_rel_phy", alloc_phy, 5);
        check("t3_rel_count", free_count, 1);

        // T4: overflow on full list; 8'hFF is ignored
        do_reset();
        release_valid = 1; release_phy = 8'hFF;
        cyc();
        idle(); #1;
        check("t4_ff_overflow", overflow_err, 0);
        check("t4_ff_count", free_count, 128);
        release_valid = 1; release_phy = 8'd40;
        cyc();
        idle(); #1;
        check("t4_overflow", overflow_err, 1);
        check("t4_full_count", free_count, 128);
        check("t4_mem_intact", alloc_phy, 32);
        do_reset();
        alloc_req = 1; release_valid = 1; release_phy = 8'd40;
        cyc();
        idle(); #1;
        check("t4_pop_push_ovf", overflow_err, 1);
        check("t4_pop_push_cnt", free_count, 127);
        check("t4_pop_push_phy", alloc_phy, 33);

        // T6: pointer wrap with round-robin returns
        do_reset();
        q.delete();
        for (int i = 0; i < 128; i++) q.push_back(8'(32 + i));
        alloc_req = 1;
        cyc();
        void'(q.pop_front());
        release_valid = 1;
        for (int i = 0; i < 200; i++) begin
            exp_tag = q.pop_front();
            release_phy = exp_tag;
            #1;
            check("t6_wrap_phy", alloc_phy, exp_tag);
            q.push_back(exp_tag);
            cyc();
        end
        alloc_req = 0; release_phy = 8'd32;
        q.push_back(8'd32);
        cyc();
        idle(); #1;
        check("t6_count", free_count, 128);
        check("t6_head_phy", alloc_phy, q[0]);
        save_state = 1; save_page = 3;
        cyc();
        idle();
        exception_sig = 1;
        cyc();
        idle(); #1;
        check("t6_exc_phy", alloc_phy, 32);
        check("t6_exc_valid", alloc_valid, 1);
        check("t6_exc_count", free_count, 128);
        restore_state = 1; restore_page = 3; #1;
        check("t6_exc_ckpt", alloc_phy, 32);
        idle();

        // mret reinitialises too
        alloc_req = 1; release_valid = 1; release_phy = 8'd40;
        cyc();
        idle(); #1;
        check("mret_pre_ovf", overflow_err, 1);
        mret_sig = 1;
        cyc();
        idle(); #1;
        check("mret_ovf", overflow_err, 0);
        check("mret_phy", alloc_phy, 32);
        check("mret_count", free_count, 128);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
